mc_main_controller: RTL and testbench

- Multicycle RV32I control FSM that sits directly upstream of the ALU.
- Decodes the latched instruction fields and drives the ALU operation code, the ALU operand-select muxes and all datapath write enables.
- Consumes the ALU Zero and SignBit flags to resolve branches.
- Handshakes with instruction/data memory through mem_ready.

---
 rtl/mc_ctrl_pkg.sv | 73 +++++++
 rtl/mc_alu_decoder.sv | 40 ++++
 rtl/mc_main_controller.sv | 217 +++++++++++++++++++++
 tb/tb_mc_main_controller.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multicycle RV32I main controller.
// Holds the FSM state encoding, the RV32I opcodes the controller decodes,
// the ALU operation codes and the encodings of every datapath select.
package mc_ctrl_pkg;

  localparam int ALU_OP_W = 3;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXEC_R   = 4'd6,
    EXEC_I   = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    JAL      = 4'd10,
    JALR     = 4'd11,
    LINK     = 4'd12,
    LUI      = 4'd13,
    ILLEGAL  = 4'd14
  } state_t;

  // Operation class handed to the ALU decoder by the FSM.
  typedef enum logic [1:0] {
    ACLS_ADD = 2'd0,  // address / PC arithmetic
    ACLS_SUB = 2'd1,  // branch compare
    ACLS_R   = 2'd2,  // register-register arithmetic
    ACLS_I   = 2'd3   // register-immediate arithmetic
  } alu_cls_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IARITH = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [ALU_OP_W-1:0] ALU_ADD = 3'b000;
  localparam logic [ALU_OP_W-1:0] ALU_SUB = 3'b001;
  localparam logic [ALU_OP_W-1:0] ALU_AND = 3'b010;
  localparam logic [ALU_OP_W-1:0] ALU_OR  = 3'b011;
  localparam logic [ALU_OP_W-1:0] ALU_XOR = 3'b100;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_REGA  = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_REGB  = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_MEMDATA   = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // funct3 values supported for arithmetic: add/sub, xor, or, and.
  function automatic logic arith_f3_ok(input logic [2:0] f3);
    return (f3 == 3'b000) || (f3 == 3'b100) || (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

endpackage

// File: rtl/mc_alu_decoder.sv
// Combinational ALU operation decoder.
// Ports:
//   alu_cls  - operation class chosen by the FSM (see alu_cls_t)
//   funct3   - instr[14:12]
//   funct7_5 - instr[30], selects sub for register-register add
//   alu_op   - ALU operation code
module mc_alu_decoder
  import mc_ctrl_pkg::*;
(
  input  logic [1:0]          alu_cls,
  input  logic [2:0]          funct3,
  input  logic                funct7_5,
  output logic [ALU_OP_W-1:0] alu_op
);

  logic [ALU_OP_W-1:0] arith_op;

  // Shared funct3 map for R and I arithmetic; sub only exists for R-type.
  always_comb begin
    arith_op = ALU_ADD;
    case (funct3)
      3'b000:  arith_op = (funct7_5 && (alu_cls == ACLS_R)) ? ALU_SUB : ALU_ADD;
      3'b100:  arith_op = ALU_XOR;
      3'b110:  arith_op = ALU_OR;
      3'b111:  arith_op = ALU_AND;
      default: arith_op = ALU_ADD;
    endcase
  end

  always_comb begin
    alu_op = ALU_ADD;
    case (alu_cls)
      ACLS_SUB: alu_op = ALU_SUB;
      ACLS_R:   alu_op = arith_op;
      ACLS_I:   alu_op = arith_op;
      default:  alu_op = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_main_controller.sv
// Multicycle RV32I main control FSM sitting upstream of the ALU.
// Decodes the latched instruction fields and drives the ALU op, the operand
// select muxes and the datapath write enables; resolves branches from the ALU
// zero/sign flags and stalls on mem_ready during fetch and data accesses.
// Ports:
//   clk, rst_n          - clock, synchronous active-low reset
//   opcode/funct3/funct7_5 - instruction fields from the IR
//   zero, sign_bit      - ALU flags
//   mem_ready           - memory access completes this cycle
//   alu_op, alu_src_a, alu_src_b, imm_src, result_src, adr_src - datapath selects
//   pc_write, ir_write, mem_write, reg_write - write enables
//   illegal_instr       - sticky, set on entry to the illegal state
//   instr_retired       - pulse in the last cycle of each instruction
//   state_dbg           - current FSM state
// Handshake: mem_ready is a single-cycle completion strobe; the controller holds
// its address/enable outputs stable until it sees mem_ready=1 and only samples
// it in FETCH, MEMREAD and MEMWRITE.
module mc_main_controller
  import mc_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [6:0]          opcode,
  input  logic [2:0]          funct3,
  input  logic                funct7_5,
  input  logic                zero,
  input  logic                sign_bit,
  input  logic                mem_ready,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic [1:0]          alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [2:0]          imm_src,
  output logic [1:0]          result_src,
  output logic                adr_src,
  output logic                pc_write,
  output logic                ir_write,
  output logic                mem_write,
  output logic                reg_write,
  output logic                illegal_instr,
  output logic                instr_retired,
  output logic [3:0]          state_dbg
);

  state_t   state;
  state_t   next_state;
  state_t   decode_next;
  alu_cls_t alu_cls;
  logic     branch_taken;
  logic     illegal_q;
  logic     pc_write_raw;
  logic     ir_write_raw;
  logic     mem_write_raw;
  logic     reg_write_raw;
  logic     retire_raw;

  mc_alu_decoder u_alu_decoder (
    .alu_cls  (alu_cls),
    .funct3   (funct3),
    .funct7_5 (funct7_5),
    .alu_op   (alu_op)
  );

  // Instruction legality and dispatch target out of DECODE.
  always_comb begin
    decode_next = ILLEGAL;
    case (opcode)
      OP_LOAD:   decode_next = (funct3 == 3'b010) ? MEMADR : ILLEGAL;
      OP_STORE:  decode_next = (funct3 == 3'b010) ? MEMADR : ILLEGAL;
      OP_RTYPE:  decode_next = (arith_f3_ok(funct3) && (!funct7_5 || funct3 == 3'b000))
                               ? EXEC_R : ILLEGAL;
      OP_IARITH: decode_next = arith_f3_ok(funct3) ? EXEC_I : ILLEGAL;
      OP_BRANCH: decode_next = (funct3 == 3'b000 || funct3 == 3'b001 ||
                                funct3 == 3'b100 || funct3 == 3'b101) ? BRANCH : ILLEGAL;
      OP_JAL:    decode_next = JAL;
      OP_JALR:   decode_next = (funct3 == 3'b000) ? JALR : ILLEGAL;
      OP_LUI:    decode_next = LUI;
      default:   decode_next = ILLEGAL;
    endcase
  end

  // beq/bne use the zero flag of RegA-RegB; blt/bge use the sign bit alone,
  // so signed overflow is not corrected.
  always_comb begin
    branch_taken = 1'b0;
    case (funct3)
      3'b000:  branch_taken = zero;
      3'b001:  branch_taken = !zero;
      3'b100:  branch_taken = sign_bit;
      3'b101:  branch_taken = !sign_bit;
      default: branch_taken = 1'b0;
    endcase
  end

  always_comb begin
    next_state    = state;
    alu_cls       = ACLS_ADD;
    alu_src_a     = SRCA_PC;
    alu_src_b     = SRCB_REGB;
    imm_src       = IMM_I;
    result_src    = RES_ALUOUT;
    adr_src       = 1'b0;
    pc_write_raw  = 1'b0;
    ir_write_raw  = 1'b0;
    mem_write_raw = 1'b0;
    reg_write_raw = 1'b0;
    retire_raw    = 1'b0;
    case (state)
      FETCH: begin
        alu_src_b    = SRCB_FOUR;
        result_src   = RES_ALURESULT;
        ir_write_raw = mem_ready;
        pc_write_raw = mem_ready;
        if (mem_ready) next_state = DECODE;
      end
      DECODE: begin
        // Precompute the PC-relative target into ALUOut for branch/jal.
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_IMM;
        imm_src    = (opcode == OP_JAL) ? IMM_J : IMM_B;
        next_state = decode_next;
      end
      MEMADR: begin
        alu_src_a  = SRCA_REGA;
        alu_src_b  = SRCB_IMM;
        imm_src    = (opcode == OP_STORE) ? IMM_S : IMM_I;
        next_state = (opcode == OP_STORE) ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        adr_src = 1'b1;
        if (mem_ready) next_state = MEMWB;
      end
      MEMWB: begin
        result_src    = RES_MEMDATA;
        reg_write_raw = 1'b1;
        retire_raw    = 1'b1;
        next_state    = FETCH;
      end
      MEMWRITE: begin
        adr_src       = 1'b1;
        mem_write_raw = 1'b1;
        retire_raw    = mem_ready;
        if (mem_ready) next_state = FETCH;
      end
      EXEC_R: begin
        alu_cls    = ACLS_R;
        alu_src_a  = SRCA_REGA;
        alu_src_b  = SRCB_REGB;
        next_state = ALUWB;
      end
      EXEC_I: begin
        alu_cls    = ACLS_I;
        alu_src_a  = SRCA_REGA;
        alu_src_b  = SRCB_IMM;
        next_state = ALUWB;
      end
      ALUWB: begin
        reg_write_raw = 1'b1;
        retire_raw    = 1'b1;
        next_state    = FETCH;
      end
      BRANCH: begin
        alu_cls      = ACLS_SUB;
        alu_src_a    = SRCA_REGA;
        alu_src_b    = SRCB_REGB;
        pc_write_raw = branch_taken;
        retire_raw   = 1'b1;
        next_state   = FETCH;
      end
      JAL: begin
        pc_write_raw = 1'b1;
        next_state   = LINK;
      end
      JALR: begin
        alu_src_a    = SRCA_REGA;
        alu_src_b    = SRCB_IMM;
        result_src   = RES_ALURESULT;
        pc_write_raw = 1'b1;
        next_state   = LINK;
      end
      LINK: begin
        // Link value OldPC+4 goes through ALUOut to ALUWB.
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        next_state = ALUWB;
      end
      LUI: begin
        alu_src_a  = SRCA_ZERO;
        alu_src_b  = SRCB_IMM;
        imm_src    = IMM_U;
        next_state = ALUWB;
      end
      ILLEGAL: next_state = ILLEGAL;
      default: next_state = ILLEGAL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= FETCH;
      illegal_q <= 1'b0;
    end else begin
      state <= next_state;
      if (next_state == ILLEGAL) illegal_q <= 1'b1;
    end
  end

  // Reset suppresses every side effect combinationally, so an instruction
  // caught mid-flight by reset never writes or retires.
  assign pc_write      = rst_n & pc_write_raw;
  assign ir_write      = rst_n & ir_write_raw;
  assign mem_write     = rst_n & mem_write_raw;
  assign reg_write     = rst_n & reg_write_raw;
  assign instr_retired = rst_n & retire_raw;
  assign illegal_instr = illegal_q;
  assign state_dbg     = state;

endmodule

// File: tb/tb_mc_main_controller.sv
module tb_mc_main_controller;

  // State codes of the controller as seen on state_dbg.
  localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMREAD = 4'd3;
  localparam logic [3:0] S_MEMWB = 4'd4, S_MEMWRITE = 4'd5, S_EXEC_R = 4'd6, S_EXEC_I = 4'd7;
  localparam logic [3:0] S_ALUWB = 4'd8, S_BRANCH = 4'd9, S_JAL = 4'd10, S_JALR = 4'd11;
  localparam logic [3:0] S_LINK = 4'd12, S_LUI = 4'd13, S_ILLEGAL = 4'd14;

  localparam logic [6:0] O_LW = 7'b0000011, O_SW = 7'b0100011, O_R = 7'b0110011;
  localparam logic [6:0] O_I = 7'b0010011, O_BR = 7'b1100011, O_JAL = 7'b1101111;
  localparam logic [6:0] O_JALR = 7'b1100111, O_LUI = 7'b0110111, O_BAD = 7'h7F;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       zero;
  logic       sign_bit;
  logic       mem_ready;
  logic [2:0] alu_op;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] imm_src;
  logic [1:0] result_src;
  logic       adr_src;
  logic       pc_write;
  logic       ir_write;
  logic       mem_write;
  logic       reg_write;
  logic       illegal_instr;
  logic       instr_retired;
  logic [3:0] state_dbg;

  int compared = 0;
  int mismatched = 0;

  typedef struct packed {
    logic        rst;
    logic        mr;
    logic        z;
    logic        s;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic [3:0]  st;
    logic [18:0] v;
  } step_t;

  step_t seq[$];

  logic [18:0] obs;
  assign obs = {alu_op, alu_src_a, alu_src_b, imm_src, result_src, adr_src,
                pc_write, ir_write, mem_write, reg_write, illegal_instr, instr_retired};

  mc_main_controller dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
    .zero(zero), .sign_bit(sign_bit), .mem_ready(mem_ready), .alu_op(alu_op),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_src(imm_src),
    .result_src(result_src), .adr_src(adr_src), .pc_write(pc_write),
    .ir_write(ir_write), .mem_write(mem_write), .reg_write(reg_write),
    .illegal_instr(illegal_instr), .instr_retired(instr_retired), .state_dbg(state_dbg)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Expected control word builders.
  function automatic logic [18:0] ctl(input logic [2:0] op, input logic [1:0] a, input logic [1:0] b,
                                      input logic [2:0] imm, input logic [1:0] res, input logic adr,
                                      input logic pcw, input logic irw, input logic mw,
                                      input logic rw, input logic ill, input logic ret);
    return {op, a, b, imm, res, adr, pcw, irw, mw, rw, ill, ret};
  endfunction

  function automatic logic [18:0] v_fetch(input logic mr);
    return ctl(3'b000, 2'b00, 2'b10, 3'b000, 2'b10, 1'b0, mr, mr, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic logic [18:0] v_decode(input logic [2:0] imm);
    return ctl(3'b000, 2'b01, 2'b01, imm, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic logic [18:0] v_exec_r(input logic [2:0] op);
    return ctl(op, 2'b10, 2'b00, 3'b000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic logic [18:0] v_exec_i(input logic [2:0] op);
    return ctl(op, 2'b10, 2'b01, 3'b000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic logic [18:0] v_aluwb();
    return ctl(3'b000, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
  endfunction
  function automatic logic [18:0] v_memadr(input logic [2:0] imm);
    return ctl(3'b000, 2'b10, 2'b01, imm, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic logic [18:0] v_memread();
    return ctl(3'b000, 2'b00, 2'b00, 3'b000, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic logic [18:0] v_memwb();
    return ctl(3'b000, 2'b00, 2'b00, 3'b000, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
  endfunction
  function automatic logic [18:0] v_memwrite(input logic mw, input logic ret);
    return ctl(3'b000, 2'b00, 2'b00, 3'b000, 2'b00, 1'b1, 1'b0, 1'b0, mw, 1'b0, 1'b0, ret);
  endfunction
  function automatic logic [18:0] v_branch(input logic taken);
    return ctl(3'b001, 2'b10, 2'b00, 3'b000, 2'b00, 1'b0, taken, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endfunction
  function automatic logic [18:0] v_jal();
    return ctl(3'b000, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic logic [18:0] v_jalr();
    return ctl(3'b000, 2'b10, 2'b01, 3'b000, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic logic [18:0] v_link();
    return ctl(3'b000, 2'b01, 2'b10, 3'b000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic logic [18:0] v_lui();
    return ctl(3'b000, 2'b11, 2'b01, 3'b100, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic logic [18:0] v_illegal();
    return ctl(3'b000, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endfunction

  function automatic step_t mk(input logic rst, input logic mr, input logic z, input logic s,
                               input logic [6:0] op, input logic [2:0] f3, input logic f7,
                               input logic [3:0] st, input logic [18:0] v);
    step_t e;
    e = '{rst: rst, mr: mr, z: z, s: s, op: op, f3: f3, f7: f7, st: st, v: v};
    return e;
  endfunction

  // Driver: apply one step's inputs just after the clock edge.
  task automatic drive(input step_t e);
    rst_n = e.rst; mem_ready = e.mr; zero = e.z; sign_bit = e.s;
    opcode = e.op; funct3 = e.f3; funct7_5 = e.f7;
  endtask

  // Adds one normal instruction prefix: FETCH with ready, then DECODE.
  task automatic push_fd(input logic [6:0] op, input logic [2:0] f3, input logic f7, input logic [2:0] imm);
    seq.push_back(mk(1, 1, 0, 0, op, f3, f7, S_FETCH, v_fetch(1)));
    seq.push_back(mk(1, 1, 0, 0, op, f3, f7, S_DECODE, v_decode(imm)));
  endtask

  task automatic test_reset();
    seq.delete();
    seq.push_back(mk(0, 1, 0, 0, O_R, 3'b000, 0, S_FETCH, v_fetch(0)));
    seq.push_back(mk(1, 0, 0, 0, O_R, 3'b000, 0, S_FETCH, v_fetch(0)));
    for (int i = 0; i < seq.size(); i++) begin
      drive(seq[i]); #2;
      compared++;
      if ({state_dbg, obs} !== {seq[i].st, seq[i].v}) begin
        mismatched++;
        $display("FAIL reset step %0d: state=%0d ctl=%h, expected state=%0d ctl=%h", i, state_dbg, obs, seq[i].st, seq[i].v);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_r_type();
    seq.delete();
    // add x3,x1,x2 then sub x3,x1,x2
    push_fd(O_R, 3'b000, 0, 3'b010);
    seq.push_back(mk(1, 1, 0, 0, O_R, 3'b000, 0, S_EXEC_R, v_exec_r(3'b000)));
    seq.push_back(mk(1, 1, 0, 0, O_R, 3'b000, 0, S_ALUWB, v_aluwb()));
    push_fd(O_R, 3'b000, 1, 3'b010);
    seq.push_back(mk(1, 0, 0, 0, O_R, 3'b000, 1, S_EXEC_R, v_exec_r(3'b001)));
    seq.push_back(mk(1, 0, 0, 0, O_R, 3'b000, 1, S_ALUWB, v_aluwb()));
    push_fd(O_R, 3'b111, 0, 3'b010);
    seq.push_back(mk(1, 0, 0, 0, O_R, 3'b111, 0, S_EXEC_R, v_exec_r(3'b010)));
    seq.push_back(mk(1, 0, 0, 0, O_R, 3'b111, 0, S_ALUWB, v_aluwb()));
    seq.push_back(mk(1, 0, 0, 0, O_R, 3'b111, 0, S_FETCH, v_fetch(0)));
    for (int i = 0; i < seq.size(); i++) begin
      drive(seq[i]); #2;
      compared++;
      if ({state_dbg, obs} !== {seq[i].st, seq[i].v}) begin
        mismatched++;
        $display("FAIL r_type step %0d: state=%0d ctl=%h, expected state=%0d ctl=%h", i, state_dbg, obs, seq[i].st, seq[i].v);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_i_type();
    seq.delete();
    // xori, then ori and addi with funct7_5 set (must not become sub)
    push_fd(O_I, 3'b100, 0, 3'b010);
    seq.push_back(mk(1, 1, 0, 0, O_I, 3'b100, 0, S_EXEC_I, v_exec_i(3'b100)));
    seq.push_back(mk(1, 1, 0, 0, O_I, 3'b100, 0, S_ALUWB, v_aluwb()));
    push_fd(O_I, 3'b110, 0, 3'b010);
    seq.push_back(mk(1, 1, 0, 0, O_I, 3'b110, 0, S_EXEC_I, v_exec_i(3'b011)));
    seq.push_back(mk(1, 1, 0, 0, O_I, 3'b110, 0, S_ALUWB, v_aluwb()));
    push_fd(O_I, 3'b000, 1, 3'b010);
    seq.push_back(mk(1, 1, 0, 0, O_I, 3'b000, 1, S_EXEC_I, v_exec_i(3'b000)));
    seq.push_back(mk(1, 1, 0, 0, O_I, 3'b000, 1, S_ALUWB, v_aluwb()));
    seq.push_back(mk(1, 0, 0, 0, O_I, 3'b000, 1, S_FETCH, v_fetch(0)));
    for (int i = 0; i < seq.size(); i++) begin
      drive(seq[i]); #2;
      compared++;
      if ({state_dbg, obs} !== {seq[i].st, seq[i].v}) begin
        mismatched++;
        $display("FAIL i_type step %0d: state=%0d ctl=%h, expected state=%0d ctl=%h", i, state_dbg, obs, seq[i].st, seq[i].v);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_lw_stall();
    seq.delete();
    for (int k = 0; k < 3; k++) seq.push_back(mk(1, 0, 0, 0, O_LW, 3'b010, 0, S_FETCH, v_fetch(0)));
    push_fd(O_LW, 3'b010, 0, 3'b010);
    seq.push_back(mk(1, 1, 0, 0, O_LW, 3'b010, 0, S_MEMADR, v_memadr(3'b000)));
    for (int k = 0; k < 3; k++) seq.push_back(mk(1, 0, 0, 0, O_LW, 3'b010, 0, S_MEMREAD, v_memread()));
    seq.push_back(mk(1, 1, 0, 0, O_LW, 3'b010, 0, S_MEMREAD, v_memread()));
    seq.push_back(mk(1, 1, 0, 0, O_LW, 3'b010, 0, S_MEMWB, v_memwb()));
    seq.push_back(mk(1, 0, 0, 0, O_LW, 3'b010, 0, S_FETCH, v_fetch(0)));
    for (int i = 0; i < seq.size(); i++) begin
      drive(seq[i]); #2;
      compared++;
      if ({state_dbg, obs} !== {seq[i].st, seq[i].v}) begin
        mismatched++;
        $display("FAIL lw_stall step %0d: state=%0d ctl=%h, expected state=%0d ctl=%h", i, state_dbg, obs, seq[i].st, seq[i].v);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch();
    seq.delete();
    // beq z=1 taken, beq z=0 not, bge s=1 not, blt s=1 taken, bne z=0 taken
    push_fd(O_BR, 3'b000, 0, 3'b010);
    seq.push_back(mk(1, 1, 1, 0, O_BR, 3'b000, 0, S_BRANCH, v_branch(1)));
    push_fd(O_BR, 3'b000, 0, 3'b010);
    seq.push_back(mk(1, 1, 0, 1, O_BR, 3'b000, 0, S_BRANCH, v_branch(0)));
    push_fd(O_BR, 3'b101, 0, 3'b010);
    seq.push_back(mk(1, 1, 0, 1, O_BR, 3'b101, 0, S_BRANCH, v_branch(0)));
    push_fd(O_BR, 3'b100, 0, 3'b010);
    seq.push_back(mk(1, 1, 1, 1, O_BR, 3'b100, 0, S_BRANCH, v_branch(1)));
    push_fd(O_BR, 3'b001, 0, 3'b010);
    seq.push_back(mk(1, 1, 0, 0, O_BR, 3'b001, 0, S_BRANCH, v_branch(1)));
    seq.push_back(mk(1, 0, 0, 0, O_BR, 3'b001, 0, S_FETCH, v_fetch(0)));
    for (int i = 0; i < seq.size(); i++) begin
      drive(seq[i]); #2;
      compared++;
      if ({state_dbg, obs} !== {seq[i].st, seq[i].v}) begin
        mismatched++;
        $display("FAIL branch step %0d: state=%0d ctl=%h, expected state=%0d ctl=%h", i, state_dbg, obs, seq[i].st, seq[i].v);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_jumps();
    seq.delete();
    push_fd(O_JAL, 3'b000, 0, 3'b011);
    seq.push_back(mk(1, 1, 0, 0, O_JAL, 3'b000, 0, S_JAL, v_jal()));
    seq.push_back(mk(1, 1, 0, 0, O_JAL, 3'b000, 0, S_LINK, v_link()));
    seq.push_back(mk(1, 1, 0, 0, O_JAL, 3'b000, 0, S_ALUWB, v_aluwb()));
    push_fd(O_JALR, 3'b000, 0, 3'b010);
    seq.push_back(mk(1, 1, 0, 0, O_JALR, 3'b000, 0, S_JALR, v_jalr()));
    seq.push_back(mk(1, 1, 0, 0, O_JALR, 3'b000, 0, S_LINK, v_link()));
    seq.push_back(mk(1, 1, 0, 0, O_JALR, 3'b000, 0, S_ALUWB, v_aluwb()));
    push_fd(O_LUI, 3'b101, 0, 3'b010);
    seq.push_back(mk(1, 1, 0, 0, O_LUI, 3'b101, 0, S_LUI, v_lui()));
    seq.push_back(mk(1, 1, 0, 0, O_LUI, 3'b101, 0, S_ALUWB, v_aluwb()));
    seq.push_back(mk(1, 0, 0, 0, O_LUI, 3'b101, 0, S_FETCH, v_fetch(0)));
    for (int i = 0; i < seq.size(); i++) begin
      drive(seq[i]); #2;
      compared++;
      if ({state_dbg, obs} !== {seq[i].st, seq[i].v}) begin
        mismatched++;
        $display("FAIL jumps step %0d: state=%0d ctl=%h, expected state=%0d ctl=%h", i, state_dbg, obs, seq[i].st, seq[i].v);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_sw_reset();
    seq.delete();
    // Normal store completing with ready, then a stalled store aborted by reset.
    push_fd(O_SW, 3'b010, 0, 3'b010);
    seq.push_back(mk(1, 0, 0, 0, O_SW, 3'b010, 0, S_MEMADR, v_memadr(3'b001)));
    seq.push_back(mk(1, 1, 0, 0, O_SW, 3'b010, 0, S_MEMWRITE, v_memwrite(1, 1)));
    push_fd(O_SW, 3'b010, 0, 3'b010);
    seq.push_back(mk(1, 1, 0, 0, O_SW, 3'b010, 0, S_MEMADR, v_memadr(3'b001)));
    seq.push_back(mk(1, 0, 0, 0, O_SW, 3'b010, 0, S_MEMWRITE, v_memwrite(1, 0)));
    seq.push_back(mk(1, 0, 0, 0, O_SW, 3'b010, 0, S_MEMWRITE, v_memwrite(1, 0)));
    seq.push_back(mk(0, 1, 0, 0, O_SW, 3'b010, 0, S_MEMWRITE, v_memwrite(0, 0)));
    seq.push_back(mk(1, 0, 0, 0, O_SW, 3'b010, 0, S_FETCH, v_fetch(0)));
    for (int i = 0; i < seq.size(); i++) begin
      drive(seq[i]); #2;
      compared++;
      if ({state_dbg, obs} !== {seq[i].st, seq[i].v}) begin
        mismatched++;
        $display("FAIL sw_reset step %0d: state=%0d ctl=%h, expected state=%0d ctl=%h", i, state_dbg, obs, seq[i].st, seq[i].v);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_illegal();
    seq.delete();
    // opcode 0x7F: absorbing for 20 cycles, reset clears the flag.
    push_fd(O_BAD, 3'b000, 0, 3'b010);
    for (int k = 0; k < 20; k++)
      seq.push_back(mk(1, 1, k[0], k[1], O_BAD, 3'b000, 0, S_ILLEGAL, v_illegal()));
    seq.push_back(mk(0, 1, 0, 0, O_BAD, 3'b000, 0, S_ILLEGAL, v_illegal()));
    seq.push_back(mk(1, 0, 0, 0, O_BAD, 3'b000, 0, S_FETCH, v_fetch(0)));
    // R-type with unsupported funct3, and with funct7_5 outside add/sub.
    push_fd(O_R, 3'b001, 0, 3'b010);
    seq.push_back(mk(1, 1, 0, 0, O_R, 3'b001, 0, S_ILLEGAL, v_illegal()));
    seq.push_back(mk(0, 0, 0, 0, O_R, 3'b001, 0, S_ILLEGAL, v_illegal()));
    push_fd(O_R, 3'b100, 1, 3'b010);
    seq.push_back(mk(1, 1, 0, 0, O_R, 3'b100, 1, S_ILLEGAL, v_illegal()));
    seq.push_back(mk(0, 0, 0, 0, O_R, 3'b100, 1, S_ILLEGAL, v_illegal()));
    // lw with wrong width is illegal too.
    push_fd(O_LW, 3'b000, 0, 3'b010);
    seq.push_back(mk(1, 1, 0, 0, O_LW, 3'b000, 0, S_ILLEGAL, v_illegal()));
    seq.push_back(mk(0, 0, 0, 0, O_LW, 3'b000, 0, S_ILLEGAL, v_illegal()));
    seq.push_back(mk(1, 0, 0, 0, O_LW, 3'b000, 0, S_FETCH, v_fetch(0)));
    for (int i = 0; i < seq.size(); i++) begin
      drive(seq[i]); #2;
      compared++;
      if ({state_dbg, obs} !== {seq[i].st, seq[i].v}) begin
        mismatched++;
        $display("FAIL illegal step %0d: state=%0d ctl=%h, expected state=%0d ctl=%h", i, state_dbg, obs, seq[i].st, seq[i].v);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst_n = 1'b0; mem_ready = 1'b0; zero = 1'b0; sign_bit = 1'b0;
    opcode = 7'd0; funct3 = 3'd0; funct7_5 = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    test_reset();
    test_r_type();
    test_i_type();
    test_lw_stall();
    test_branch();
    test_jumps();
    test_sw_reset();
    test_illegal();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
